// File: rtl/pt_responder_pkg.sv
// Shared types and constants for the page-table-walk responder.
package pt_responder_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_RESP = 3'd3,
    ST_WR_DONE = 3'd4
  } state_e;

  localparam int unsigned PT_ENTRIES_DEF = 256;
  localparam logic [7:0]  PTE_INVALID    = 8'h00;

  // PTE bit positions as seen by the MMU
  localparam int PTE_VALID_BIT = 7;
  localparam int PTE_USER_BIT  = 6;
  localparam int PTE_WRITE_BIT = 5;
  localparam int PTE_EXEC_BIT  = 4;

  // True when addr lies in [base, base+entries) with 16-bit wraparound
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int unsigned entries);
    logic [15:0] off;
    off = addr - base;
    return {16'b0, off} < entries;
  endfunction

endpackage

// File: rtl/pt_responder_timeout.sv
// Loadable down-counter bounding one memory transaction.
module pt_responder_timeout #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload while idle so a fresh transaction starts at CYCLES-1; count down on each waiting cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CW'(CYCLES - 1);
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Expires in the CYCLES-th waiting cycle; the caller gives a same-cycle ack priority
  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/pt_responder.sv
// Memory-side responder for the MMU page-table-walk port: PTE reads, PTE
// write-through updates with TLB flush detection, and transaction timeouts.
module pt_responder
  import pt_responder_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int unsigned PT_ENTRIES     = PT_ENTRIES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pt_addr,
  input  logic        pt_read,
  output logic [7:0]  pt_data,
  output logic        pt_ready,
  input  logic [15:0] page_table_base,
  input  logic        upd_valid,
  input  logic [15:0] upd_addr,
  input  logic [7:0]  upd_data,
  output logic        upd_ready,
  output logic        tlb_flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        err_clear,
  output logic        err_timeout,
  output logic        err_overrun
);

  state_e      state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [7:0]  pt_data_q, pt_data_d;
  logic        pt_ready_q, pt_ready_d;
  logic        upd_ready_q, upd_ready_d;
  logic        tlb_flush_q, tlb_flush_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_overrun_q, err_overrun_d;
  logic        expire;

  pt_responder_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == ST_IDLE),
    .en     (mem_req_q && !mem_ack),
    .expire (expire)
  );

  // Next-state and registered-output computation for the sequencer
  always_comb begin
    state_d       = state_q;
    rd_pend_d     = rd_pend_q;
    rd_addr_d     = rd_addr_q;
    pt_data_d     = pt_data_q;
    pt_ready_d    = 1'b0;
    upd_ready_d   = 1'b0;
    tlb_flush_d   = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_timeout_d = err_timeout_q & ~err_clear;
    err_overrun_d = err_overrun_q & ~err_clear;

    // Single-entry read capture; a second request while one is pending is lost
    if (pt_read) begin
      if (rd_pend_q) begin
        err_overrun_d = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = pt_addr;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_pend_q) begin
          state_d    = ST_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr_q;
        end else if (upd_valid && !pt_read) begin
          // A read arriving this cycle beats a waiting update
          state_d     = ST_WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = upd_addr;
          mem_wdata_d = upd_data;
        end
      end
      ST_RD: begin
        if (mem_ack || expire) begin
          pt_data_d  = mem_ack ? mem_rdata : PTE_INVALID;
          state_d    = ST_RD_RESP;
          mem_req_d  = 1'b0;
          pt_ready_d = 1'b1;
          if (!mem_ack) err_timeout_d = 1'b1;
        end
      end
      ST_RD_RESP: begin
        rd_pend_d = 1'b0;
        state_d   = ST_IDLE;
      end
      ST_WR: begin
        if (mem_ack || expire) begin
          state_d     = ST_WR_DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          upd_ready_d = 1'b1;
          // The write landed (or was abandoned) either way, so stale TLB entries must go
          tlb_flush_d = in_window(mem_addr_q, page_table_base, PT_ENTRIES);
          if (!mem_ack) err_timeout_d = 1'b1;
        end
      end
      ST_WR_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset discards any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      pt_data_q     <= '0;
      pt_ready_q    <= 1'b0;
      upd_ready_q   <= 1'b0;
      tlb_flush_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_pend_q     <= rd_pend_d;
      rd_addr_q     <= rd_addr_d;
      pt_data_q     <= pt_data_d;
      pt_ready_q    <= pt_ready_d;
      upd_ready_q   <= upd_ready_d;
      tlb_flush_q   <= tlb_flush_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign pt_data     = pt_data_q;
  assign pt_ready    = pt_ready_q;
  assign upd_ready   = upd_ready_q;
  assign tlb_flush   = tlb_flush_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_pt_responder.sv
// Bench for pt_responder: scripted memory, transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pt_responder;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pt_addr;
  logic        pt_read;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic [15:0] page_table_base;
  logic        upd_valid;
  logic [15:0] upd_addr;
  logic [7:0]  upd_data;
  logic        upd_ready;
  logic        tlb_flush;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        err_clear;
  logic        err_timeout;
  logic        err_overrun;

  int n_chk = 0;
  int n_err = 0;

  pt_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pt_addr         (pt_addr),
    .pt_read         (pt_read),
    .pt_data         (pt_data),
    .pt_ready        (pt_ready),
    .page_table_base (page_table_base),
    .upd_valid       (upd_valid),
    .upd_addr        (upd_addr),
    .upd_data        (upd_data),
    .upd_ready       (upd_ready),
    .tlb_flush       (tlb_flush),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .err_clear       (err_clear),
    .err_timeout     (err_timeout),
    .err_overrun     (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scripted memory ----------------
  logic [7:0] mem_arr [0:65535];
  bit  ack_en    = 1'b1;
  int  ack_lat   = 3;
  bit  force_ack = 1'b0;
  int  req_cyc   = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h3C;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        if (ack_en && req_cyc == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_arr[mem_addr];
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'h3C;
        end
        req_cyc++;
      end else begin
        mem_ack   = force_ack;
        mem_rdata = 8'h77;
        req_cyc   = 0;
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          m_rd_out, m_busy, m_is_rd, m_rd_done, m_wr_done, m_flush;
  bit          m_err_t, m_err_o, prev_req;
  logic [15:0] m_rd_addr, m_waddr;
  logic [7:0]  m_data;
  int          m_cnt;
  int          n_ready = 0;

  initial begin
    bit          nt, no;
    logic [15:0] off;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_rd_out = 0; m_busy = 0; m_is_rd = 0; m_rd_done = 0; m_wr_done = 0;
        m_flush = 0; m_err_t = 0; m_err_o = 0; prev_req = 0; m_data = 8'h00;
        m_cnt = 0; m_rd_addr = '0; m_waddr = '0;
      end else begin
        if (pt_ready) n_ready++;
        check("pt_ready",    32'(pt_ready),    32'(m_rd_done));
        check("upd_ready",   32'(upd_ready),   32'(m_wr_done));
        check("tlb_flush",   32'(tlb_flush),   32'(m_wr_done && m_flush));
        check("pt_data",     32'(pt_data),     32'(m_data));
        check("err_timeout", 32'(err_timeout), 32'(m_err_t));
        check("err_overrun", 32'(err_overrun), 32'(m_err_o));
        if (m_rd_done || m_wr_done) check("mem_req_drop", 32'(mem_req), 32'd0);

        nt = m_err_t & ~err_clear;
        no = m_err_o & ~err_clear;

        // A new memory transaction must serve the pending read, else the update
        if (mem_req && !prev_req) begin
          m_busy = 1; m_cnt = 0; m_is_rd = m_rd_out;
          if (m_rd_out) begin
            check("rd_we",   32'(mem_we),   32'd0);
            check("rd_addr", 32'(mem_addr), 32'(m_rd_addr));
          end else begin
            check("wr_has_upd", 32'(upd_valid), 32'd1);
            check("wr_we",      32'(mem_we),    32'd1);
            check("wr_addr",    32'(mem_addr),  32'(upd_addr));
            check("wr_data",    32'(mem_wdata), 32'(upd_data));
            m_waddr = upd_addr;
          end
        end

        if (pt_read) begin
          if (m_rd_out) no = 1;
          else begin m_rd_out = 1; m_rd_addr = pt_addr; end
        end
        if (m_rd_done) m_rd_out = 0;

        m_rd_done = 0;
        m_wr_done = 0;
        if (mem_req && m_busy) begin
          if (mem_ack || m_cnt == TO - 1) begin
            if (!mem_ack) nt = 1;
            if (m_is_rd) begin
              m_rd_done = 1;
              m_data    = mem_ack ? mem_rdata : 8'h00;
            end else begin
              m_wr_done = 1;
              off       = m_waddr - page_table_base;
              m_flush   = (off < 16'd256);
            end
            m_busy = 0;
          end else begin
            m_cnt++;
          end
        end
        m_err_t  = nt;
        m_err_o  = no;
        prev_req = mem_req;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_read(input logic [15:0] a);
    pt_read = 1'b1; pt_addr = a;
    @(posedge clk); #1;
    pt_read = 1'b0;
  endtask

  // Called at #1 after an edge; returns edges until pt_ready is seen
  task automatic wait_ready(output int k);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      k++;
      if (pt_ready) return;
    end
    check("wait_ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_upd(input logic [15:0] a, input logic [7:0] d, output bit fl);
    fl = 1'b0;
    upd_valid = 1'b1; upd_addr = a; upd_data = d;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (upd_ready) begin
        fl = tlb_flush;
        upd_valid = 1'b0;
        return;
      end
    end
    upd_valid = 1'b0;
    check("upd_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int k, cnt, rd_idx, wr_idx;
    bit fl, wfl;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'(i * 7 + 3);
    mem_arr[16'h1042] = 8'hE5;
    rst_n = 1'b0; pt_read = 0; pt_addr = '0; page_table_base = 16'h1000;
    upd_valid = 0; upd_addr = '0; upd_data = '0; err_clear = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 32'({pt_ready, upd_ready, tlb_flush, mem_req, mem_we, err_timeout, err_overrun}), 32'd0);
    check("rst_data", 32'({pt_data, mem_wdata, mem_addr}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic read, ack 3 cycles after mem_req
    ack_lat = 3;
    pulse_read(16'h1042);
    check("t1_no_req_yet", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("t1_mem_req",  32'(mem_req),  32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'h1042);
    check("t1_mem_we",   32'(mem_we),   32'd0);
    wait_ready(k);
    check("t1_latency", 32'(k + 1), 32'd5);
    check("t1_data",    32'(pt_data), 32'hE5);
    @(posedge clk); #1;
    check("t1_ready_pulse", 32'(pt_ready), 32'd0);
    check("t1_data_held",   32'(pt_data),  32'hE5);
    repeat (3) @(posedge clk); #1;

    // 2: read timeout
    ack_en = 0;
    pulse_read(16'h2000);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (mem_req) cnt++;
      if (pt_ready) break;
    end
    check("t2_req_cycles", 32'(cnt), 32'd64);
    check("t2_ready",      32'(pt_ready), 32'd1);
    check("t2_data",       32'(pt_data), 32'h00);
    @(posedge clk); #1;
    check("t2_err_t", 32'(err_timeout), 32'd1);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check("t2_err_clr", 32'(err_timeout), 32'd0);
    ack_en = 1;

    // 3: updates, flush window including wraparound
    ack_lat = 1;
    do_upd(16'h10FF, 8'hA3, fl);
    check("t3_flush_in", 32'(fl), 32'd1);
    check("t3_mem_wr",   32'(mem_arr[16'h10FF]), 32'hA3);
    @(posedge clk); #1;
    do_upd(16'h1100, 8'h11, fl);
    check("t3_flush_out", 32'(fl), 32'd0);
    @(posedge clk); #1;
    page_table_base = 16'hFF80;
    do_upd(16'h0010, 8'h22, fl);
    check("t3_flush_wrap", 32'(fl), 32'd1);
    @(posedge clk); #1;
    page_table_base = 16'h1000;

    // 4: read and update arrive together; read served first
    ack_lat = 2;
    pt_read = 1; pt_addr = 16'h1042;
    upd_valid = 1; upd_addr = 16'h1010; upd_data = 8'h5C;
    @(posedge clk); #1;
    pt_read = 0;
    rd_idx = -1; wr_idx = -1; wfl = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (pt_ready && rd_idx < 0) rd_idx = i;
      if (upd_ready) begin wr_idx = i; wfl = tlb_flush; upd_valid = 0; break; end
    end
    upd_valid = 0;
    check("t4_read_seen",  32'(rd_idx >= 0), 32'd1);
    check("t4_read_first", 32'(rd_idx < wr_idx), 32'd1);
    check("t4_flush",      32'(wfl), 32'd1);
    repeat (2) @(posedge clk); #1;

    // 5: overrun while a read is pending
    ack_lat = 6;
    n_ready = 0;
    pulse_read(16'h1042);
    @(posedge clk); #1;
    pulse_read(16'h3333);
    repeat (30) @(posedge clk); #1;
    check("t5_one_ready", 32'(n_ready), 32'd1);
    check("t5_data",      32'(pt_data), 32'hE5);
    check("t5_overrun",   32'(err_overrun), 32'd1);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check("t5_ovr_clr", 32'(err_overrun), 32'd0);

    // 6: reset mid-transaction, late ack ignored, then normal service
    ack_en = 0;
    pulse_read(16'h1042);
    for (int i = 0; i < 20 && !mem_req; i++) begin @(posedge clk); #1; end
    check("t6_req_up", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_clr", 32'({pt_ready, upd_ready, tlb_flush, mem_req, mem_we, err_timeout, err_overrun}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    n_ready = 0;
    repeat (10) @(posedge clk); #1;
    check("t6_no_late_ready", 32'(n_ready), 32'd0);
    ack_en = 1; ack_lat = 0;
    pulse_read(16'h1042);
    wait_ready(k);
    check("t6_min_latency", 32'(k), 32'd2);
    check("t6_data",        32'(pt_data), 32'hE5);
    repeat (3) @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
